ntt_pointwise_mac_stream: RTL and testbench
===========================================

NTT_POINTWISE_MAC_STREAM -- requirements
Module: ntt_pointwise_mac_stream

Interface
REQ-001 SHALL have parameter N, default 256: coefficients per polynomial.
REQ-002 SHALL have parameter WIDTH, default 32: coefficient bit width.
REQ-003 SHALL have parameter Q, default 3329: modulus, Q < 2^(WIDTH-1).
REQ-004 SHALL have parameter LANES, default 4: coefficients per beat; N divisible by LANES; BEATS = N/LANES.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port mode  input  2  00=MUL a*b, 01=MAC c+a*b, 10=MSUB c-a*b, 11=MUL.
REQ-008 SHALL have port in_valid  input  1  input beat valid.
REQ-009 SHALL have port in_ready  output  1  input beat accepted when in_valid & in_ready.
REQ-010 SHALL have ports in_a, in_b, in_c  input  LANES*WIDTH each  lane k at bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid  output  1  output beat valid.
REQ-012 SHALL have port out_ready  input  1  output beat consumed when out_valid & out_ready.
REQ-013 SHALL have port out_c  output  LANES*WIDTH  result lanes, same packing.
REQ-014 SHALL have port out_last  output  1  high with final beat (index BEATS-1) of a polynomial.
REQ-015 SHALL have port poly_done  output  1  one-cycle pulse per completed polynomial.
REQ-016 SHALL have port busy  output  1  high while any beat is in flight or a polynomial is partially input.

Function
REQ-017 Per lane k, SHALL compute out_c[k] = (a*b) mod Q, (c + a*b) mod Q, or (c - a*b) mod Q per mode; result always in [0, Q-1], upper bits zero.
REQ-018 Inputs SHALL be taken as in range [0, Q-1]; behaviour for out-of-range inputs is unspecified, not checked.
REQ-019 Product SHALL be computed at full 2*WIDTH precision with no truncation before reduction.
REQ-020 Datapath SHALL be a 3-stage pipeline: S1 register inputs, S2 multiply, S3 reduce/add/sub; out_valid rises 3 cycles after acceptance with out_ready held high.
REQ-021 Pipeline SHALL advance all stages when advance = !out_valid | out_ready; otherwise every stage holds.
REQ-022 in_ready SHALL equal advance; no beat is dropped or duplicated under any out_ready pattern.
REQ-023 Bubbles SHALL propagate as invalid stages; full throughput is one beat per cycle.
REQ-024 out_c, out_last SHALL remain stable while out_valid & !out_ready.
REQ-025 An input beat counter (0..BEATS-1) SHALL increment per accepted beat and wrap to 0 after BEATS-1.
REQ-026 mode SHALL be sampled on the accepted beat with counter 0 and applied to all BEATS beats of that polynomial; changes mid-polynomial are ignored.
REQ-027 out_last SHALL be carried down the pipeline with its beat, set for input index BEATS-1.
REQ-028 poly_done SHALL pulse in the cycle after the out_last beat handshakes.
REQ-029 Back-to-back polynomials SHALL stream with no idle cycle; each uses its own latched mode.
REQ-030 busy SHALL be high when any stage is valid or the input counter is nonzero.

Reset
REQ-031 On rst_n low, all outputs SHALL go to 0 immediately: out_valid, out_c, out_last, poly_done, busy.
REQ-032 Reset SHALL clear all stage valid bits, the beat counter, and the latched mode (to MUL).
REQ-033 Reset mid-polynomial SHALL discard in-flight beats; the next accepted beat after release is index 0 of a new polynomial.
REQ-034 in_ready SHALL be 1 during and after reset, since no stage is valid.

Verification
REQ-035 MUL, a=b=3328 all lanes, out_ready=1 -> out_c lanes = 1, out_valid 3 cycles after accept.
REQ-036 MAC, a=2, b=1665, c=3328 -> 0; MSUB, a=1, b=1, c=0 -> 3328.
REQ-037 64 beats streamed continuously (N=256, LANES=4) -> out_last only on beat 64, poly_done one cycle later, 64 outputs in order.
REQ-038 out_ready low 5 cycles mid-stream -> in_ready low same cycles, out_c stable, full sequence intact.
REQ-039 mode switched MUL->MAC at beat 10 -> whole polynomial uses MUL; next polynomial uses MAC.
REQ-040 rst_n low at beat 20 -> outputs 0 at once; next stream's out_last on its 64th beat.

Source files
------------

// File: rtl/ntt_pointwise_mac_stream.sv
// Streaming per-lane modular multiply / multiply-accumulate for NTT-domain polynomials.
// Three-stage pipeline (register, multiply, reduce) with a global stall on output back-pressure.
module ntt_pointwise_mac_stream #(
    parameter int N     = 256,
    parameter int WIDTH = 32,
    parameter int Q     = 3329,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [LANES*WIDTH-1:0] in_c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_c,
    output logic                   out_last,
    output logic                   poly_done,
    output logic                   busy
);

    localparam int BEATS = N / LANES;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);
    localparam logic [2*WIDTH-1:0] QP = (2*WIDTH)'(Q);
    localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);

    logic [CW-1:0] cnt;
    logic [1:0] mode_q;
    logic [1:0] beat_mode;
    logic advance;
    logic accept;

    logic v1, v2;
    logic l1, l2;
    logic [1:0] m1, m2;
    logic [LANES*WIDTH-1:0] a1, b1, c1, c2;
    logic [LANES-1:0][2*WIDTH-1:0] p_n, p2;
    logic [LANES*WIDTH-1:0] r_n;

    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid & advance;
    // Mode is taken from the port only on the first beat of a polynomial.
    assign beat_mode = (cnt == '0) ? mode : mode_q;
    assign busy      = v1 | v2 | out_valid | (cnt != '0);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] pm;
        logic [WIDTH-1:0] ck;
        logic [WIDTH:0] sum;
        logic [WIDTH:0] sum_r;
        logic [WIDTH:0] dif;
        logic [WIDTH-1:0] r;

        assign p_n[k] = {{WIDTH{1'b0}}, a1[k*WIDTH +: WIDTH]}
                      * {{WIDTH{1'b0}}, b1[k*WIDTH +: WIDTH]};

        assign pm    = WIDTH'(p2[k] % QP);
        assign ck    = c2[k*WIDTH +: WIDTH];
        assign sum   = {1'b0, ck} + {1'b0, pm};
        assign sum_r = (sum >= QX) ? sum - QX : sum;
        assign dif   = (ck >= pm) ? {1'b0, ck} - {1'b0, pm}
                                  : {1'b0, ck} + QX - {1'b0, pm};

        always_comb begin
            r = pm;
            unique case (m2)
                2'b01:   r = WIDTH'(sum_r);
                2'b10:   r = WIDTH'(dif);
                default: r = pm;
            endcase
        end

        assign r_n[k*WIDTH +: WIDTH] = r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mode_q    <= 2'b00;
            v1        <= 1'b0;
            v2        <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
            m1        <= 2'b00;
            m2        <= 2'b00;
            a1        <= '0;
            b1        <= '0;
            c1        <= '0;
            c2        <= '0;
            p2        <= '0;
            out_valid <= 1'b0;
            out_c     <= '0;
            out_last  <= 1'b0;
            poly_done <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= (cnt == LAST_IDX) ? '0 : cnt + CW'(1);
                if (cnt == '0) begin
                    mode_q <= mode;
                end
            end
            if (advance) begin
                v1        <= in_valid;
                a1        <= in_a;
                b1        <= in_b;
                c1        <= in_c;
                m1        <= beat_mode;
                l1        <= (cnt == LAST_IDX);
                v2        <= v1;
                p2        <= p_n;
                c2        <= c1;
                m2        <= m1;
                l2        <= l1;
                out_valid <= v2;
                out_c     <= r_n;
                out_last  <= l2;
            end
            poly_done <= out_valid & out_ready & out_last;
        end
    end

endmodule

// File: tb/tb_ntt_pointwise_mac_stream.sv
// Scoreboard bench for ntt_pointwise_mac_stream: directed polynomials,
// stall, mid-polynomial mode change and mid-stream reset.
module tb_ntt_pointwise_mac_stream;

    localparam int W = 32;
    localparam int L = 4;
    localparam int Q = 3329;
    localparam int BEATS = 64;

    typedef logic [L*W-1:0] beat_t;
    typedef struct {
        beat_t c;
        logic  last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic in_valid = 1'b0;
    logic in_ready;
    beat_t in_a = '0;
    beat_t in_b = '0;
    beat_t in_c = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    beat_t out_c;
    logic out_last;
    logic poly_done;
    logic busy;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    ntt_pointwise_mac_stream #(
        .N(256), .WIDTH(W), .Q(Q), .LANES(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_last(out_last),
        .poly_done(poly_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic beat_t rep(int v);
        beat_t r;
        for (int k = 0; k < L; k++) r[k*W +: W] = W'(v);
        return r;
    endfunction

    function automatic beat_t lanes(int base);
        beat_t r;
        for (int k = 0; k < L; k++) r[k*W +: W] = W'(base + k);
        return r;
    endfunction

    // kind 0: a*1, 1: 3328+a, 2: 7+a, 3: 0-a  (lane a = base+k, a < 256)
    function automatic beat_t expv(int kind, int base);
        beat_t r;
        int a;
        for (int k = 0; k < L; k++) begin
            a = base + k;
            case (kind)
                1:       r[k*W +: W] = W'(a - 1);
                2:       r[k*W +: W] = W'(a + 7);
                3:       r[k*W +: W] = W'(Q - a);
                default: r[k*W +: W] = W'(a);
            endcase
        end
        return r;
    endfunction

    task automatic check1(string name, logic [L*W-1:0] act, logic [L*W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(logic [1:0] md, beat_t a, beat_t b, beat_t c,
                        beat_t e, logic last);
        int n;
        exp_t x;
        mode = md;
        in_a = a;
        in_b = b;
        in_c = c;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        x.c = e;
        x.last = last;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    logic pend = 1'b0;
    logic stalled = 1'b0;
    beat_t held_c;
    logic held_last;

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            pend = 1'b0;
            stalled = 1'b0;
        end else begin
            if (pend || poly_done) begin
                checks++;
                if (poly_done !== pend) begin
                    failures++;
                    $display("FAIL poly_done actual=%b required=%b", poly_done, pend);
                end
            end
            if (stalled) begin
                checks++;
                if (out_c !== held_c || out_last !== held_last) begin
                    failures++;
                    $display("FAIL stall_hold actual=%h/%b required=%h/%b",
                             out_c, out_last, held_c, held_last);
                end
            end
            pend = 1'b0;
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none", out_c);
                end else begin
                    x = sb.pop_front();
                    if (out_c !== x.c || out_last !== x.last) begin
                        failures++;
                        $display("FAIL beat actual=%h/%b required=%h/%b",
                                 out_c, out_last, x.c, x.last);
                    end
                end
                pend = out_last;
            end else if (out_valid) begin
                stalled = 1'b1;
                held_c = out_c;
                held_last = out_last;
            end
        end
    end

    initial begin
        int n;
        #2;
        check1("reset_out_valid", beat_t'(out_valid), '0);
        check1("reset_out_c", out_c, '0);
        check1("reset_flags", beat_t'({out_last, poly_done, busy}), '0);
        check1("reset_in_ready", beat_t'(in_ready), beat_t'(1));
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Poly 1: MUL, first beat 3328*3328 -> 1, check latency
        send(2'b00, rep(3328), rep(3328), rep(0), rep(1), 1'b0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("latency", beat_t'(n), beat_t'(3));
        @(posedge clk);
        #1;
        for (int i = 1; i < BEATS; i++)
            send(2'b00, lanes(i*4), rep(1), rep(0), expv(0, i*4), i == BEATS-1);

        // Poly 2: MAC back-to-back, with a 5-cycle output stall
        fork
            begin
                send(2'b01, rep(2), rep(1665), rep(3328), rep(0), 1'b0);
                for (int i = 1; i < BEATS; i++)
                    send(2'b01, lanes(i*4), rep(1), rep(3328), expv(1, i*4),
                         i == BEATS-1);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check1("stall_in_ready", beat_t'(in_ready), '0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Poly 3: MUL, port mode flips to MAC at beat 10 (ignored)
        for (int i = 0; i < BEATS; i++)
            send((i < 10) ? 2'b00 : 2'b01, lanes(i*4), rep(1), rep(7),
                 expv(0, i*4), i == BEATS-1);

        // Poly 4: MAC from the start
        for (int i = 0; i < BEATS; i++)
            send(2'b01, lanes(i*4), rep(1), rep(7), expv(2, i*4), i == BEATS-1);

        // Poly 5: MSUB, interrupted by reset after 20 beats
        send(2'b10, rep(1), rep(1), rep(0), rep(3328), 1'b0);
        for (int i = 1; i < 20; i++)
            send(2'b10, lanes(i*4), rep(1), rep(0), expv(3, i*4), 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check1("rst_out_valid", beat_t'(out_valid), '0);
        check1("rst_out_c", out_c, '0);
        check1("rst_flags", beat_t'({out_last, poly_done, busy}), '0);
        check1("rst_in_ready", beat_t'(in_ready), beat_t'(1));
        sb.delete();
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Poly 6: fresh MUL stream, last must land on its own 64th beat
        for (int i = 0; i < BEATS; i++)
            send(2'b00, lanes(i*4), rep(1), rep(0), expv(0, i*4), i == BEATS-1);
        in_valid = 1'b0;

        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check1("drain_queue", beat_t'(sb.size()), '0);
        repeat (3) @(negedge clk);
        check1("idle_busy", beat_t'(busy), '0);
        check1("idle_out_valid", beat_t'(out_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
